pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001: The module SHALL have parameter N, default 32, which sets the address and instruction width.
REQ-002: The module SHALL have parameter RESET_PC, default 32'h00000000, which is the PC loaded on reset.
REQ-003: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004: rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-005: redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-006: redirect_pc  input  N  redirect target.
REQ-007: imem_req  output  1  fetch request to instruction memory.
REQ-008: imem_addr  output  N  fetch address, equal to the current pc.
REQ-009: imem_ready  input  1  memory accepts the request this cycle when imem_req is also high.
REQ-010: imem_rvalid  input  1  read data valid, one cycle, at least 1 cycle after acceptance.
REQ-011: imem_rdata  input  N  fetched instruction.
REQ-012: instr_valid  output  1  held instruction valid to decode.
REQ-013: instr_ready  input  1  decode consumes the instruction when instr_valid is also high.
REQ-014: instr  output  N  held instruction.
REQ-015: instr_pc  output  N  PC of the held instruction.
REQ-016: pc_plus4  output  N  instr_pc + 4 (mod 2^N), combinational.

Function
REQ-017: The FSM SHALL have states FETCH, WAIT and HOLD, with at most one outstanding memory request.
REQ-018: FETCH: imem_req = 1 and imem_addr = pc. On imem_ready, the FSM SHALL go to WAIT.
REQ-019: WAIT: imem_req = 0. On imem_rvalid with discard = 0, the FSM SHALL latch instr <= imem_rdata and instr_pc <= pc, set instr_valid = 1, and go to HOLD.
REQ-020: HOLD: instr_valid = 1, and instr and instr_pc SHALL stay stable. On instr_ready: pc <= pc + 4, instr_valid <= 0, go to FETCH.
REQ-021: Minimum throughput SHALL be one instruction per 3 cycles; imem_rvalid to instr_valid latency SHALL be 1 cycle.
REQ-022: PC arithmetic SHALL be modulo 2^N: 0xFFFFFFFC + 4 = 0x00000000 (N = 32), with no error flag.
REQ-023: pc[1:0] SHALL always be 0; redirect_pc[1:0] SHALL be ignored (forced to 00).
REQ-024: Redirect in FETCH without imem_ready: pc <= redirect_pc, stay in FETCH, and the new address SHALL be presented on the next cycle.
REQ-025: Redirect in FETCH with imem_ready in the same cycle: pc <= redirect_pc, go to WAIT with discard <= 1.
REQ-026: Redirect in WAIT: pc <= redirect_pc, discard <= 1. If imem_rvalid occurs in the same cycle, the response SHALL be dropped and the FSM SHALL go directly to FETCH.
REQ-027: WAIT with discard = 1: on imem_rvalid, the data SHALL be dropped, discard <= 0, go to FETCH; instr_valid SHALL stay 0.
REQ-028: Redirect in HOLD (with or without instr_ready): the held instruction SHALL be dropped, instr_valid <= 0, pc <= redirect_pc (not pc + 4), go to FETCH.
REQ-029: imem_rvalid SHALL be ignored in FETCH and HOLD.
REQ-030: Redirect SHALL take priority over every other event in the same cycle.

Reset
REQ-031: While rst = 1, imem_req and instr_valid SHALL be 0, and redirect and all memory inputs SHALL be ignored.
REQ-032: On the rising edge with rst = 1, the module SHALL set pc <= RESET_PC, state <= FETCH, discard <= 0, instr_valid <= 0, instr <= 0, instr_pc <= 0.
REQ-033: Reset asserted mid-transaction (WAIT or HOLD) SHALL abandon that transaction; a late imem_rvalid after reset release in FETCH SHALL be ignored.
REQ-034: The first request after release SHALL be imem_addr = RESET_PC on the first cycle with rst = 0.

Verification
REQ-035: Basic fetch: reset, imem_ready = 1 always, rvalid 1 cycle after accept, instr_ready = 1 -> addresses 0x0, 0x4, 0x8, each instr_pc matches, and pc_plus4 = instr_pc + 4.
REQ-036: Backpressure: instr_ready = 0 for 5 cycles in HOLD -> instr_valid, instr and instr_pc stable and imem_req = 0; consumption then produces the fetch at instr_pc + 4.
REQ-037: Redirect in WAIT: request to 0x10 accepted, redirect to 0x200 (low bits 0x203 -> 0x200), rvalid returns 0xDEADBEEF -> no instr_valid, next imem_addr = 0x200.
REQ-038: Redirect in HOLD with instr_ready in the same cycle: held instr at 0x40, redirect to 0x80 -> next imem_addr = 0x80, not 0x44.
REQ-039: Wrap: redirect to 0xFFFFFFFC, consume -> next imem_addr = 0x00000000.
REQ-040: Reset mid-WAIT, with rvalid arriving 2 cycles after release -> ignored, imem_addr = RESET_PC, instr_valid = 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- single-outstanding instruction fetch controller.
//
// Walks a program counter through instruction memory one request at a time.
// Each instruction goes through three states: FETCH issues the request, WAIT
// collects the response, and HOLD presents the instruction to decode until
// decode consumes it. A redirect (branch/jump) overrides every other event in
// the same cycle. A response that belongs to an abandoned request is dropped
// through the discard flag.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   redirect_valid in   one-cycle redirect request
//   redirect_pc    in   [N] redirect target (bits [1:0] ignored)
//   imem_req       out  fetch request (high only in FETCH, low in reset)
//   imem_addr      out  [N] fetch address (the current pc)
//   imem_ready     in   memory accepts the request this cycle
//   imem_rvalid    in   one-cycle read data valid
//   imem_rdata     in   [N] fetched instruction
//   instr_valid    out  held instruction is valid
//   instr_ready    in   decode consumes the held instruction
//   instr          out  [N] held instruction
//   instr_pc       out  [N] pc of the held instruction
//   pc_plus4       out  [N] instr_pc + 4, wrapping modulo 2^N

module pc_fetch_ctrl #(
    parameter int              N        = 32,
    parameter logic [N-1:0]    RESET_PC = 32'h00000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc,
    output logic [N-1:0] pc_plus4
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [N-1:0] PC_STEP = N'(4);

    state_t         state_reg,       state_next;
    logic [N-1:0]   pc_reg,          pc_next;
    logic           discard_reg,     discard_next;
    logic           instr_valid_reg, instr_valid_next;
    logic [N-1:0]   instr_reg,       instr_next;
    logic [N-1:0]   instr_pc_reg,    instr_pc_next;

    // Word alignment: the two low pc bits are always zero, so redirect
    // targets and the reset pc are forced to a word boundary.
    logic [N-1:0]   redirect_target;
    logic [N-1:0]   reset_pc_aligned;
    logic [N-1:0]   pc_incr;
    logic           unused_low_bits;

    assign redirect_target  = {redirect_pc[N-1:2], 2'b00};
    assign reset_pc_aligned = {RESET_PC[N-1:2], 2'b00};
    assign pc_incr          = pc_reg + PC_STEP;
    assign unused_low_bits  = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FETCH;
            pc_reg          <= reset_pc_aligned;
            discard_reg     <= 1'b0;
            instr_valid_reg <= 1'b0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            discard_reg     <= discard_next;
            instr_valid_reg <= instr_valid_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Redirect is evaluated first in every state so it
    // wins over acceptance, responses and consumption.
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        discard_next     = discard_reg;
        instr_valid_next = instr_valid_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;

        unique case (state_reg)
            FETCH: begin
                // imem_rvalid is meaningless here: nothing is outstanding.
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_ready) begin
                        // The old address was accepted anyway; its reply
                        // must be thrown away when it comes back.
                        state_next   = WAIT;
                        discard_next = 1'b1;
                    end
                end else if (imem_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_rvalid) begin
                        // Reply for the stale address arrives together with
                        // the redirect: drop it and refetch immediately.
                        state_next   = FETCH;
                        discard_next = 1'b0;
                    end else begin
                        discard_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard_reg) begin
                        state_next   = FETCH;
                        discard_next = 1'b0;
                    end else begin
                        state_next       = HOLD;
                        instr_next       = imem_rdata;
                        instr_pc_next    = pc_reg;
                        instr_valid_next = 1'b1;
                    end
                end
            end

            HOLD: begin
                // imem_rvalid is ignored; instr/instr_pc stay frozen.
                if (redirect_valid) begin
                    pc_next          = redirect_target;
                    instr_valid_next = 1'b0;
                    state_next       = FETCH;
                end else if (instr_ready) begin
                    pc_next          = pc_incr;
                    instr_valid_next = 1'b0;
                    state_next       = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Handshake outputs are gated by rst so they are low for the
    // whole time reset is asserted, including the very first reset cycle.
    // ------------------------------------------------------------------
    assign imem_req    = !rst && (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign instr_valid = !rst && instr_valid_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign pc_plus4    = instr_pc_reg + PC_STEP;

endmodule
